// File: rtl/power_stage_sequencer.sv
// Staged thermometer enable sequencer: ramps hash-core groups on one at a time
// after the settled qualifier rises, and sheds them in reverse order when it drops.
module power_stage_sequencer #(
    parameter int N_STAGES      = 4,
    parameter int GAP_BITS      = 3,
    parameter int DOWN_GAP_BITS = 2
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                ready_in,
    input  logic                hold,
    output logic [N_STAGES-1:0] stage_en,
    output logic                all_on,
    output logic                busy,
    output logic [7:0]          abort_cnt
);

    localparam int CNT_W = (GAP_BITS > DOWN_GAP_BITS) ? GAP_BITS : DOWN_GAP_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] DOWN = 2'd3;

    localparam logic [CNT_W-1:0]    UP_LAST   = CNT_W'((1 << GAP_BITS) - 1);
    localparam logic [CNT_W-1:0]    DOWN_LAST = CNT_W'((1 << DOWN_GAP_BITS) - 1);
    localparam logic [N_STAGES-1:0] ALL_ONES  = {N_STAGES{1'b1}};
    localparam logic [N_STAGES-1:0] FIRST_EN  = N_STAGES'(1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;

    logic [1:0]          state_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [N_STAGES-1:0] stage_en_d;
    logic                all_on_d;
    logic                busy_d;
    logic [7:0]          abort_cnt_d;

    logic                stop_req;
    logic [N_STAGES-1:0] en_grow;
    logic [N_STAGES-1:0] en_shrink;

    // A stop request is anything that should end a ramp-up or the ON state.
    assign stop_req  = ~ready_in | hold;
    assign en_grow   = (stage_en << 1) | FIRST_EN;
    assign en_shrink = stage_en >> 1;

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        stage_en_d  = stage_en;
        all_on_d    = all_on;
        busy_d      = busy;
        abort_cnt_d = abort_cnt;

        case (state)
            IDLE: begin
                if (ready_in && !hold) begin
                    state_d    = UP;
                    stage_en_d = FIRST_EN;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                end
            end

            UP: begin
                // Abort wins over a stage advance landing on the same edge.
                if (stop_req) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    if (abort_cnt != 8'hFF) begin
                        abort_cnt_d = abort_cnt + 8'd1;
                    end
                end else if (cnt == UP_LAST) begin
                    cnt_d = '0;
                    if (stage_en == ALL_ONES) begin
                        state_d  = ON;
                        all_on_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        stage_en_d = en_grow;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            ON: begin
                if (stop_req) begin
                    state_d  = DOWN;
                    all_on_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end

            DOWN: begin
                // Ramp-down always runs to completion; inputs are ignored here.
                if (cnt == DOWN_LAST) begin
                    cnt_d      = '0;
                    stage_en_d = en_shrink;
                    if (en_shrink == '0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                stage_en_d = '0;
                all_on_d   = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stage_en  <= '0;
            all_on    <= 1'b0;
            busy      <= 1'b0;
            abort_cnt <= 8'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            stage_en  <= stage_en_d;
            all_on    <= all_on_d;
            busy      <= busy_d;
            abort_cnt <= abort_cnt_d;
        end
    end

    a_thermometer: assert property (@(posedge CLK) disable iff (!reset_n)
        ((stage_en & (stage_en + N_STAGES'(1))) == '0));

    a_all_on_full: assert property (@(posedge CLK) disable iff (!reset_n)
        (all_on |-> stage_en == ALL_ONES));

    a_exclusive: assert property (@(posedge CLK) disable iff (!reset_n)
        !(all_on && busy));

endmodule

// File: tb/tb_power_stage_sequencer.sv
// Randomised and directed bench for power_stage_sequencer, compared every cycle
// against a time-based model of the ramp (stages = elapsed edges / gap).
module tb_power_stage_sequencer;

    localparam int N     = 4;
    localparam int GAP   = 8;
    localparam int DGAP  = 4;

    logic         CLK;
    logic         reset_n;
    logic         ready_in;
    logic         hold;
    logic [N-1:0] stage_en;
    logic         all_on;
    logic         busy;
    logic [7:0]   abort_cnt;

    int n_checks;
    int n_fail;
    bit cmp_en;

    power_stage_sequencer #(.N_STAGES(N), .GAP_BITS(3), .DOWN_GAP_BITS(2)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .ready_in (ready_in),
        .hold     (hold),
        .stage_en (stage_en),
        .all_on   (all_on),
        .busy     (busy),
        .abort_cnt(abort_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: mode plus edges elapsed since the phase began; the number of
    // lit stages is derived arithmetically from that elapsed time.
    typedef enum int {M_IDLE, M_UP, M_ON, M_DOWN} mode_t;
    mode_t m_mode;
    int    m_t;
    int    m_level;
    int    m_dstart;
    int    m_abort;

    always @(posedge CLK) begin
        if (!reset_n) begin
            m_mode  = M_IDLE;
            m_t     = 0;
            m_level = 0;
            m_abort = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (ready_in && !hold) begin
                    m_mode  = M_UP;
                    m_t     = 0;
                    m_level = 1;
                end
                M_UP: if (!ready_in || hold) begin
                    m_mode   = M_DOWN;
                    m_t      = 0;
                    m_dstart = m_level;
                    m_abort  = (m_abort < 255) ? m_abort + 1 : 255;
                end else begin
                    m_t = m_t + 1;
                    if (m_t == GAP * N) m_mode = M_ON;
                    else m_level = m_t / GAP + 1;
                end
                M_ON: if (!ready_in || hold) begin
                    m_mode   = M_DOWN;
                    m_t      = 0;
                    m_dstart = N;
                end
                M_DOWN: begin
                    m_t     = m_t + 1;
                    m_level = m_dstart - m_t / DGAP;
                    if (m_level == 0) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_stage_en", int'(stage_en), (1 << m_level) - 1);
            check("model_all_on", int'(all_on), int'(m_mode == M_ON));
            check("model_busy", int'(busy), int'(m_mode == M_UP || m_mode == M_DOWN));
            check("model_abort_cnt", int'(abort_cnt), m_abort);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            wait_edges(1);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cmp_en   = 0;
        reset_n  = 1'b0;
        ready_in = 1'b0;
        hold     = 1'b0;
        wait_edges(3);
        cmp_en = 1;
        check("reset_stage_en", int'(stage_en), 0);
        check("reset_all_on", int'(all_on), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_abort_cnt", int'(abort_cnt), 0);
        reset_n = 1'b1;
        wait_edges(2);

        // Full ramp-up
        ready_in = 1'b1;
        wait_edges(1);
        check("up_e0", int'(stage_en), 4'b0001);
        check("up_e0_busy", int'(busy), 1);
        wait_edges(7);
        check("up_e7", int'(stage_en), 4'b0001);
        wait_edges(1);
        check("up_e8", int'(stage_en), 4'b0011);
        wait_edges(8);
        check("up_e16", int'(stage_en), 4'b0111);
        wait_edges(8);
        check("up_e24", int'(stage_en), 4'b1111);
        check("up_e24_all_on", int'(all_on), 0);
        wait_edges(8);
        check("up_e32_all_on", int'(all_on), 1);
        check("up_e32_busy", int'(busy), 0);

        // Ramp-down from ON with a ready pulse at D6
        wait_edges(3);
        ready_in = 1'b0;
        wait_edges(1);
        check("dn_d0_all_on", int'(all_on), 0);
        check("dn_d0_busy", int'(busy), 1);
        check("dn_d0", int'(stage_en), 4'b1111);
        wait_edges(4);
        check("dn_d4", int'(stage_en), 4'b0111);
        wait_edges(1);
        ready_in = 1'b1;
        wait_edges(1);
        ready_in = 1'b0;
        wait_edges(2);
        check("dn_d8", int'(stage_en), 4'b0011);
        wait_edges(4);
        check("dn_d12", int'(stage_en), 4'b0001);
        wait_edges(4);
        check("dn_d16", int'(stage_en), 4'b0000);
        check("dn_d16_busy", int'(busy), 0);
        check("dn_no_abort", int'(abort_cnt), 0);

        // Abort mid-ramp at E10
        wait_edges(2);
        ready_in = 1'b1;
        wait_edges(10);
        ready_in = 1'b0;
        wait_edges(1);
        check("ab_e10", int'(stage_en), 4'b0011);
        check("ab_e10_cnt", int'(abort_cnt), 1);
        wait_edges(4);
        check("ab_e14", int'(stage_en), 4'b0001);
        wait_edges(4);
        check("ab_e18", int'(stage_en), 4'b0000);
        check("ab_e18_busy", int'(busy), 0);
        ready_in = 1'b1;
        wait_edges(1);
        check("ab_restart", int'(stage_en), 4'b0001);
        ready_in = 1'b0;
        wait_edges(1);
        check("ab_cnt2", int'(abort_cnt), 2);
        wait_idle("ab_idle_timeout");

        // Hold blocks ramp-up
        hold     = 1'b1;
        ready_in = 1'b1;
        wait_edges(100);
        check("hold_stage_en", int'(stage_en), 0);
        check("hold_busy", int'(busy), 0);
        hold = 1'b0;
        wait_edges(1);
        check("hold_release", int'(stage_en), 4'b0001);
        hold = 1'b1;
        wait_edges(1);
        check("hold_abort_cnt", int'(abort_cnt), 3);
        wait_idle("hold_idle_timeout");

        // Reset mid-ramp at E20
        hold = 1'b0;
        wait_edges(1);
        wait_edges(19);
        check("rst_e19", int'(stage_en), 4'b0111);
        check("rst_e19_cnt", int'(abort_cnt), 3);
        reset_n = 1'b0;
        wait_edges(1);
        check("rst_stage_en", int'(stage_en), 0);
        check("rst_all_on", int'(all_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_abort_cnt", int'(abort_cnt), 0);
        reset_n  = 1'b1;
        ready_in = 1'b0;
        wait_edges(2);

        // 300 aborted ramps saturate abort_cnt
        for (int i = 0; i < 300; i++) begin
            ready_in = 1'b1;
            wait_edges(3);
            ready_in = 1'b0;
            wait_edges(1);
            wait_idle("sat_idle_timeout");
            if (i == 254) check("sat_reach", int'(abort_cnt), 255);
        end
        check("sat_hold", int'(abort_cnt), 255);

        // Random traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15) == 0) ready_in = ~ready_in;
            if ($urandom_range(40) == 0) hold = ~hold;
            reset_n = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
            wait_edges(1);
        end
        reset_n = 1'b1;
        wait_edges(2);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
